// File: rtl/io_port_arbiter.sv
// Two-master round-robin arbiter for an 8-bit PicoBlaze-style I/O port bus.
// Define IOARB_FIXED_PRIO_EN to make master 0 win every contention (master 1 may starve).
module io_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wen,
    output logic              bus_ren,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              grant,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RDWAIT,
        ACK
    } state_t;

    // RDWAIT counts down from RD_LAT-1; the capture happens when it reaches zero.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    logic [1:0]        req_w;
    logic [1:0]        we_w;
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] wdata_w [2];
    logic [1:0]        ack_w;
    logic              win;
    logic              capture_w;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;

    assign req_w      = {m1_req, m0_req};
    assign we_w       = {m1_we, m0_we};
    assign addr_w[0]  = m0_addr;
    assign addr_w[1]  = m1_addr;
    assign wdata_w[0] = m0_wdata;
    assign wdata_w[1] = m1_wdata;

`ifdef IOARB_FIXED_PRIO_EN
    assign win = ~m0_req;
`else
    logic last_grant_q, last_grant_d;

    // Under contention the master that did not win last time goes first.
    assign win = (m0_req & m1_req) ? ~last_grant_q : ~m0_req;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && |req_w) begin
            last_grant_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            IDLE: begin
                // Address and data are loaded here so they are stable a full cycle before the strobe.
                if (|req_w) begin
                    grant_d     = win;
                    we_d        = we_w[win];
                    bus_addr_d  = addr_w[win];
                    bus_wdata_d = wdata_w[win];
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = we_q ? ACK : RDWAIT;
            end
            RDWAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            wait_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign capture_w = (state_q == RDWAIT) && (wait_cnt_q == 2'd0);

    // Per-master read-result register and ack decode; only the granted master's result moves.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic [DATA_W-1:0] rdata_q, rdata_d;

        assign ack_w[gi] = (state_q == ACK) && (grant_q == 1'(gi));

        always_comb begin
            rdata_d = rdata_q;
            if (capture_w && grant_q == 1'(gi)) begin
                rdata_d = bus_rdata;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign m0_ack    = ack_w[0];
    assign m1_ack    = ack_w[1];
    assign m0_rdata  = g_master[0].rdata_q;
    assign m1_rdata  = g_master[1].rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wen   = (state_q == STROBE) && we_q;
    assign bus_ren   = (state_q == STROBE) && !we_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed bench for io_port_arbiter: one instance at RD_LAT=1 with port models, one at RD_LAT=3.
// Cycle k is observed at the k-th falling edge after the request is raised (cycle 0 = IDLE sample).
module tb_io_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m1_ack, bus_wen, bus_ren, grant, busy;
    logic [7:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;

    logic       t_req, t_we, z_req, z_we;
    logic [7:0] t_addr, t_wdata, z_addr, z_wdata;
    logic       t_ack, t_ack1, t_wen, t_ren, t_grant, t_busy;
    logic [7:0] t_rdata, t_rdata1, t_baddr, t_bwdata, t_brdata, p1, p2;

    logic [7:0] rom  [256];
    logic [7:0] wmem [256];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] ack0_v, ack1_v, wen_v, ren_v, grant_v, busy_v;
    logic [7:0]  addr_l [16];
    logic [7:0]  wdata_l[16];
    logic [7:0]  rd0_l  [16];
    logic [7:0]  rd1_l  [16];

    always #5 clk = ~clk;

    io_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_rdata(bus_rdata), .grant(grant), .busy(busy)
    );

    io_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(t_req), .m0_we(t_we), .m0_addr(t_addr), .m0_wdata(t_wdata),
        .m0_ack(t_ack), .m0_rdata(t_rdata),
        .m1_req(z_req), .m1_we(z_we), .m1_addr(z_addr), .m1_wdata(z_wdata),
        .m1_ack(t_ack1), .m1_rdata(t_rdata1),
        .bus_addr(t_baddr), .bus_wdata(t_bwdata), .bus_wen(t_wen), .bus_ren(t_ren),
        .bus_rdata(t_brdata), .grant(t_grant), .busy(t_busy)
    );

    // Read-port mux models (one and three register stages) and a write-port bank.
    always @(posedge clk) begin
        bus_rdata <= rom[bus_addr];
        p1        <= rom[t_baddr];
        p2        <= p1;
        t_brdata  <= p2;
        if (bus_wen) wmem[bus_addr] <= bus_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic int first_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic run_cycles(input int n, input bit keep0);
        ack0_v = '0; ack1_v = '0; wen_v = '0; ren_v = '0; grant_v = '0; busy_v = '0;
        for (int k = 0; k < n; k++) begin
            ack0_v[k] = m0_ack;  ack1_v[k] = m1_ack;
            wen_v[k]  = bus_wen; ren_v[k]  = bus_ren;
            grant_v[k] = grant;  busy_v[k] = busy;
            addr_l[k] = bus_addr; wdata_l[k] = bus_wdata;
            rd0_l[k]  = m0_rdata; rd1_l[k]  = m1_rdata;
            if (m0_ack && !keep0) m0_req = 1'b0;
            if (m1_ack) m1_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic req0(input logic we, input logic [7:0] a, input logic [7:0] d);
        m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic req1(input logic we, input logic [7:0] a, input logic [7:0] d);
        m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] t_ack_v, t_ren_v, t_wen_v, t_ack1_v;
        logic [7:0]  t_rd_l [16];
        int e0, e1;

        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'h00; wmem[i] = 8'h00;
        end
        rom[2] = 8'h3C; rom[4] = 8'h5A; rom[7] = 8'h7E;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        t_req = 0; t_we = 0; t_addr = 0; t_wdata = 0;
        z_req = 0; z_we = 0; z_addr = 0; z_wdata = 0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_strobes", {bus_wen, bus_ren, m0_ack, m1_ack}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Master 0 write alone
        req0(1, 8'h05, 8'hA5);
        run_cycles(5, 0);
        check("wr_addr_c1", addr_l[1], 8'h05);
        check("wr_wdata_c1", wdata_l[1], 8'hA5);
        check("wr_wen_first", first_set(wen_v), 2);
        check("wr_wen_count", $countones(wen_v), 1);
        check("wr_ren_count", $countones(ren_v), 0);
        check("wr_ack_cycle", first_set(ack0_v), 3);
        check("wr_ack_count", $countones(ack0_v), 1);
        check("wr_idle_c4", busy_v[4], 0);
        check("wr_port5", wmem[5], 8'hA5);

        // Master 1 read alone
        req1(0, 8'h02, 8'h00);
        run_cycles(6, 0);
        check("rd1_grant_c1", grant_v[1], 1);
        check("rd1_ren_first", first_set(ren_v), 2);
        check("rd1_ren_count", $countones(ren_v), 1);
        check("rd1_ack_cycle", first_set(ack1_v), 4);
        check("rd1_rdata", rd1_l[4], 8'h3C);
        check("rd1_m0_rdata", rd0_l[5], 8'h00);
        check("rd1_no_ack0", $countones(ack0_v), 0);

        // Contention straight after reset: master 0 first
        do_reset();
        req0(1, 8'h01, 8'h11);
        req1(1, 8'h02, 8'h22);
        run_cycles(9, 0);
        check("ct_ack0_cycle", first_set(ack0_v), 3);
        check("ct_grant_c5", grant_v[5], 1);
        check("ct_addr_c5", addr_l[5], 8'h02);
        check("ct_ack1_cycle", first_set(ack1_v), 7);
        check("ct_port1", wmem[1], 8'h11);
        check("ct_port2", wmem[2], 8'h22);

        // Round robin: m1 was served last, so m0 wins
        req0(0, 8'h04, 8'h00);
        req1(1, 8'h03, 8'h33);
        run_cycles(10, 0);
        check("rr_grant_c1", grant_v[1], 0);
        check("rr_ack0_cycle", first_set(ack0_v), 4);
        check("rr_rd0", rd0_l[4], 8'h5A);
        check("rr_ack1_cycle", first_set(ack1_v), 8);
        check("rr_port3", wmem[3], 8'h33);

        // Both keep requesting; m0 never drops req
        req0(1, 8'h08, 8'h88);
        req1(1, 8'h09, 8'h99);
        run_cycles(14, 1);
`ifdef IOARB_FIXED_PRIO_EN
        e0 = 3; e1 = -1;
`else
        e0 = 2; e1 = 7;
`endif
        check("alt_ack0_count", $countones(ack0_v), e0);
        check("alt_ack1_first", first_set(ack1_v), e1);
        m0_req = 0; m1_req = 0;
        repeat (8) @(negedge clk);

        // Reset during the STROBE cycle of an m0 read
        req0(0, 8'h02, 8'h00);
        repeat (2) @(negedge clk);
        check("mr_ren_strobe", bus_ren, 1);
        rst = 1'b0; m0_req = 1'b0;
        @(negedge clk);
        check("mr_ren", bus_ren, 0);
        check("mr_busy", busy, 0);
        check("mr_ack", m0_ack, 0);
        check("mr_rdata", m0_rdata, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        req0(1, 8'h06, 8'h66);
        req1(1, 8'h07, 8'h77);
        run_cycles(9, 0);
        check("mr_grant_c1", grant_v[1], 0);
        check("mr_ack0_cycle", first_set(ack0_v), 3);
        check("mr_ack1_cycle", first_set(ack1_v), 7);

        // RD_LAT=3 instance
        t_ack_v = '0; t_ren_v = '0; t_wen_v = '0; t_ack1_v = '0;
        t_req = 1; t_we = 0; t_addr = 8'h07;
        for (int k = 0; k < 10; k++) begin
            t_ack_v[k] = t_ack; t_ren_v[k] = t_ren; t_wen_v[k] = t_wen; t_ack1_v[k] = t_ack1;
            t_rd_l[k] = t_rdata;
            if (k == 1) check("l3_grant_c1", t_grant, 0);
            if (t_ack) t_req = 0;
            @(negedge clk);
        end
        check("l3_ack_cycle", first_set(t_ack_v), 6);
        check("l3_rdata", t_rd_l[6], 8'h7E);
        check("l3_ren_first", first_set(t_ren_v), 2);
        check("l3_ren_count", $countones(t_ren_v), 1);
        check("l3_no_wen_ack1", {t_wen_v, t_ack1_v}, 0);
        check("l3_idle", {t_busy, t_bwdata, t_rdata1}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
